// File: rtl/sram_arb_pkg.sv
// Shared definitions for the SRAM arbiter: controller states, default
// SRAM geometry and the helper that sizes the requester id field.
package sram_arb_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_ADDR_W = 3;

   typedef enum logic [2:0] {
      INIT,
      CLEAR,
      IDLE,
      WR,
      RD,
      RWAIT,
      RESP
   } state_t;

   // Width of a requester index; never narrower than one bit.
   function automatic int id_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sram_rr_arb.sv
// Winner selection among asserted request valids. The default build is
// round-robin with a "last served" pointer; defining SRAM_ARB_FIXED_PRIO_EN
// switches to fixed priority (lowest index wins) and drops the pointer.
module sram_rr_arb
   import sram_arb_pkg::*;
#(
   parameter int N_REQ = 2,
   parameter int ID_W  = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req_valid,
   input  logic             enable,
   output logic [N_REQ-1:0] grant,
   output logic [ID_W-1:0]  grant_id,
   output logic             grant_any
);

   logic [ID_W-1:0] win_id;
   logic            win_found;

`ifdef SRAM_ARB_FIXED_PRIO_EN

   // Lowest asserted index wins; scanning downward lets the lowest overwrite.
   always_comb begin
      win_id    = '0;
      win_found = 1'b0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (req_valid[i]) begin
            win_id    = ID_W'(i);
            win_found = 1'b1;
         end
      end
   end

`else

   logic [ID_W-1:0] last;
   logic [ID_W-1:0] hi_id;
   logic [ID_W-1:0] lo_id;
   logic            hi_found;
   logic            lo_found;

   // Search above the pointer first, then wrap to the indices at or below it.
   always_comb begin
      hi_id    = '0;
      lo_id    = '0;
      hi_found = 1'b0;
      lo_found = 1'b0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (req_valid[i] && (i > int'(last))) begin
            hi_id    = ID_W'(i);
            hi_found = 1'b1;
         end
         if (req_valid[i] && (i <= int'(last))) begin
            lo_id    = ID_W'(i);
            lo_found = 1'b1;
         end
      end
      win_found = hi_found | lo_found;
      win_id    = hi_found ? hi_id : lo_id;
   end

   // Pointer remembers the last granted requester; reset makes requester 0 first.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last <= ID_W'(N_REQ - 1);
      end else if (grant_any) begin
         last <= grant_id;
      end
   end

`endif

   // Grant only when the controller can accept; expand the winner to one-hot.
   always_comb begin
      grant_any = enable & win_found;
      grant_id  = grant_any ? win_id : '0;
      grant     = '0;
      for (int i = 0; i < N_REQ; i++) begin
         grant[i] = grant_any && (win_id == ID_W'(i));
      end
   end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin controller that shares one single-port SRAM between N_REQ
// requesters, sequences the SRAM's synchronous clear after reset and on
// demand, and returns tagged responses on a single response channel.
// Defining SRAM_ARB_FIXED_PRIO_EN selects fixed-priority arbitration.
module sram_arbiter
   import sram_arb_pkg::*;
#(
   parameter int  N_REQ  = 2,
   parameter int  DATA_W = DEF_DATA_W,
   parameter int  ADDR_W = DEF_ADDR_W,
   localparam int ID_W   = id_width(N_REQ)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ-1:0]        req_valid,
   output logic [N_REQ-1:0]        req_ready,
   input  logic [N_REQ-1:0]        req_we,
   input  logic [N_REQ*ADDR_W-1:0] req_addr,
   input  logic [N_REQ*DATA_W-1:0] req_wdata,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [ID_W-1:0]         rsp_id,
   output logic                    rsp_we,
   output logic [DATA_W-1:0]       rsp_rdata,
   input  logic                    clear_req,
   output logic                    init_done,
   output logic                    sram_rst,
   output logic                    sram_cs,
   output logic                    sram_re,
   output logic                    sram_we,
   output logic [ADDR_W-1:0]       sram_addr,
   output logic [DATA_W-1:0]       sram_wdata,
   input  logic [DATA_W-1:0]       sram_rdata
);

   state_t state;
   state_t state_next;

   logic              pending;
   logic              clear_pend;
   logic              arb_en;
   logic [N_REQ-1:0]  grant;
   logic [ID_W-1:0]   grant_id;
   logic              grant_any;

   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic              sel_we;

   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              we_q;
   logic [ID_W-1:0]   id_q;
   logic [DATA_W-1:0] rdata_q;

   // A clear pulse seen in IDLE counts as pending at once, so it beats requests.
   assign clear_pend = pending | clear_req;
   assign arb_en     = (state == IDLE) && !clear_pend;

   sram_rr_arb #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_arb (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .enable    (arb_en),
      .grant     (grant),
      .grant_id  (grant_id),
      .grant_any (grant_any)
   );

   assign req_ready = grant;

   // Route the granted requester's fields toward the capture registers.
   always_comb begin
      sel_addr  = '0;
      sel_wdata = '0;
      sel_we    = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant[i]) begin
            sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
            sel_wdata = req_wdata[i*DATA_W +: DATA_W];
            sel_we    = req_we[i];
         end
      end
   end

   // Controller state register; reset drops any in-flight transaction.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= INIT;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: clear first, then the arbitration winner, then the access.
   always_comb begin
      state_next = state;
      case (state)
         INIT:    state_next = CLEAR;
         CLEAR:   state_next = IDLE;
         IDLE: begin
            if (clear_pend) begin
               state_next = CLEAR;
            end else if (grant_any) begin
               state_next = sel_we ? WR : RD;
            end
         end
         WR:      state_next = RESP;
         RD:      state_next = RWAIT;
         RWAIT:   state_next = RESP;
         RESP: begin
            if (rsp_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = INIT;
      endcase
   end

   // Moore decode of SRAM strobes and response valid; read and write are exclusive.
   always_comb begin
      sram_cs   = 1'b0;
      sram_rst  = 1'b0;
      sram_re   = 1'b0;
      sram_we   = 1'b0;
      rsp_valid = 1'b0;
      case (state)
         CLEAR: begin
            sram_cs  = 1'b1;
            sram_rst = 1'b1;
         end
         WR: begin
            sram_cs = 1'b1;
            sram_we = 1'b1;
         end
         RD: begin
            sram_cs = 1'b1;
            sram_re = 1'b1;
         end
         RESP:    rsp_valid = 1'b1;
         default: ;
      endcase
   end

   // Sticky clear request, consumed when the controller enters CLEAR.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pending <= 1'b0;
      end else if (state_next == CLEAR) begin
         pending <= 1'b0;
      end else if (clear_req) begin
         pending <= 1'b1;
      end
   end

   // init_done rises after the first completed clear and holds until reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         init_done <= 1'b0;
      end else if (state == CLEAR) begin
         init_done <= 1'b1;
      end
   end

   // Capture the granted request; read data is taken while the SRAM output is valid.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         id_q    <= '0;
         rdata_q <= '0;
      end else begin
         if (grant_any) begin
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            we_q    <= sel_we;
            id_q    <= grant_id;
            if (sel_we) begin
               rdata_q <= '0;
            end
         end
         if (state == RWAIT) begin
            rdata_q <= sram_rdata;
         end
      end
   end

   assign sram_addr  = addr_q;
   assign sram_wdata = wdata_q;
   assign rsp_id     = id_q;
   assign rsp_we     = we_q;
   assign rsp_rdata  = rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural 8x8 SRAM model.
// Honours SRAM_ARB_FIXED_PRIO_EN for the contention expectations.
module tb_sram_arbiter;

   localparam int N_REQ  = 2;
   localparam int DATA_W = 8;
   localparam int ADDR_W = 3;

   logic                    clk;
   logic                    rst;
   logic [N_REQ-1:0]        req_valid;
   logic [N_REQ-1:0]        req_ready;
   logic [N_REQ-1:0]        req_we;
   logic [N_REQ*ADDR_W-1:0] req_addr;
   logic [N_REQ*DATA_W-1:0] req_wdata;
   logic                    rsp_valid;
   logic                    rsp_ready;
   logic                    rsp_id;
   logic                    rsp_we;
   logic [DATA_W-1:0]       rsp_rdata;
   logic                    clear_req;
   logic                    init_done;
   logic                    sram_rst;
   logic                    sram_cs;
   logic                    sram_re;
   logic                    sram_we;
   logic [ADDR_W-1:0]       sram_addr;
   logic [DATA_W-1:0]       sram_wdata;
   logic [DATA_W-1:0]       sram_rdata;

   logic [DATA_W-1:0] mem [8];

   int total = 0;
   int bad   = 0;
   int cycle = 0;

   sram_arbiter #(
      .N_REQ  (N_REQ),
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_we     (rsp_we),
      .rsp_rdata  (rsp_rdata),
      .clear_req  (clear_req),
      .init_done  (init_done),
      .sram_rst   (sram_rst),
      .sram_cs    (sram_cs),
      .sram_re    (sram_re),
      .sram_we    (sram_we),
      .sram_addr  (sram_addr),
      .sram_wdata (sram_wdata),
      .sram_rdata (sram_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single-port SRAM: synchronous clear, write, or registered read.
   always @(posedge clk) begin
      if (sram_cs) begin
         if (sram_rst) begin
            for (int k = 0; k < 8; k++) mem[k] <= 8'h00;
            sram_rdata <= 8'h00;
         end else if (sram_we) begin
            mem[sram_addr] <= sram_wdata;
         end else if (sram_re) begin
            sram_rdata <= mem[sram_addr];
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One clock; sample 2 time units after the rising edge and check invariants.
   task automatic step();
      @(posedge clk);
      #2;
      cycle++;
      checkOutput("inv_re_we", 32'(sram_re & sram_we), 32'd0);
      checkOutput("inv_rst_cs", 32'(sram_rst & ~sram_cs), 32'd0);
      checkOutput("inv_onehot", 32'($onehot0(req_ready)), 32'd1);
   endtask

   // Issue one request, wait for the grant, then check latency and response.
   task automatic applyStimulus(input int id, input logic we, input logic [ADDR_W-1:0] addr,
                                input logic [DATA_W-1:0] wdata, input int exp_lat,
                                input logic [DATA_W-1:0] exp_data, input string tag);
      int lat;
      int waited;
      req_we[id]                    = we;
      req_addr[id*ADDR_W +: ADDR_W] = addr;
      req_wdata[id*DATA_W +: DATA_W] = wdata;
      req_valid[id]                 = 1'b1;
      #1;
      waited = 0;
      while (!req_ready[id] && waited < 10) begin
         step();
         waited++;
      end
      checkOutput({tag, "_ready"}, 32'(req_ready), 32'(1 << id));
      step();
      req_valid[id] = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 10) begin
         step();
         lat++;
      end
      checkOutput({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      checkOutput({tag, "_valid"}, 32'(rsp_valid), 32'd1);
      checkOutput({tag, "_id"}, 32'(rsp_id), 32'(id));
      checkOutput({tag, "_we"}, 32'(rsp_we), 32'(we));
      checkOutput({tag, "_rdata"}, 32'(rsp_rdata), we ? 32'd0 : 32'(exp_data));
      step();
   endtask

   initial begin
      int exp_g[4];
      int prev;
      int waited;
      int lat;

`ifdef SRAM_ARB_FIXED_PRIO_EN
      exp_g = '{0, 0, 0, 0};
`else
      exp_g = '{0, 1, 0, 1};
`endif

      for (int k = 0; k < 8; k++) mem[k] = 8'h5A ^ 8'(k);
      sram_rdata = 8'h00;
      rst        = 1'b0;
      req_valid  = '0;
      req_we     = '0;
      req_addr   = '0;
      req_wdata  = '0;
      rsp_ready  = 1'b1;
      clear_req  = 1'b0;

      $display("[TB] reset to ready");
      repeat (3) step();
      checkOutput("rst_cs", 32'(sram_cs), 32'd0);
      checkOutput("rst_srst", 32'(sram_rst), 32'd0);
      checkOutput("rst_init_done", 32'(init_done), 32'd0);
      checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("rst_rdata", 32'(rsp_rdata), 32'd0);
      rst = 1'b1;
      #1;
      checkOutput("init_cs", 32'(sram_cs), 32'd0);
      step();
      checkOutput("clear_cs", 32'(sram_cs), 32'd1);
      checkOutput("clear_srst", 32'(sram_rst), 32'd1);
      checkOutput("clear_init_done", 32'(init_done), 32'd0);
      step();
      checkOutput("idle_init_done", 32'(init_done), 32'd1);
      checkOutput("idle_cs", 32'(sram_cs), 32'd0);
      applyStimulus(0, 1'b0, 3'd5, 8'h00, 3, 8'h00, "t1_rd5");

      $display("[TB] write then read");
      applyStimulus(0, 1'b1, 3'd3, 8'hA5, 2, 8'h00, "t2_wr3");
      applyStimulus(1, 1'b0, 3'd3, 8'h00, 3, 8'hA5, "t2_rd3");

      $display("[TB] contention");
      req_we    = 2'b11;
      req_addr  = {3'd1, 3'd0};
      req_wdata = {8'h22, 8'h11};
      req_valid = 2'b11;
      #1;
      prev = 0;
      for (int g = 0; g < 4; g++) begin
         waited = 0;
         while (req_ready == '0 && waited < 10) begin
            step();
            waited++;
         end
         checkOutput($sformatf("cont_grant%0d", g), 32'(req_ready), 32'(1 << exp_g[g]));
         if (g > 0) checkOutput($sformatf("cont_gap%0d", g), 32'(cycle - prev), 32'd3);
         prev = cycle;
         step();
      end
      req_valid = '0;
      step();
      checkOutput("cont_last_rsp", 32'(rsp_valid), 32'd1);
      step();

      $display("[TB] backpressure");
      rsp_ready = 1'b0;
      req_we    = 2'b00;
      req_addr  = {3'd1, 3'd3};
      req_valid = 2'b01;
      #1;
      checkOutput("bp_ready", 32'(req_ready), 32'd1);
      step();
      req_valid = 2'b10;
      lat = 1;
      while (!rsp_valid && lat < 10) begin
         step();
         lat++;
      end
      checkOutput("bp_lat", 32'(lat), 32'd3);
      for (int i = 0; i < 5; i++) begin
         checkOutput("bp_valid", 32'(rsp_valid), 32'd1);
         checkOutput("bp_rdata", 32'(rsp_rdata), 32'hA5);
         checkOutput("bp_id", 32'(rsp_id), 32'd0);
         checkOutput("bp_req_ready", 32'(req_ready), 32'd0);
         checkOutput("bp_cs", 32'(sram_cs), 32'd0);
         step();
      end
      rsp_ready = 1'b1;
      req_valid = 2'b00;
      step();
      checkOutput("bp_done", 32'(rsp_valid), 32'd0);

      $display("[TB] clear during read");
      req_we    = 2'b00;
      req_addr  = {3'd3, 3'd3};
      req_valid = 2'b10;
      #1;
      checkOutput("clr_ready", 32'(req_ready), 32'd2);
      step();
      req_valid = 2'b00;
      clear_req = 1'b1;
      step();
      clear_req = 1'b0;
      lat = 2;
      while (!rsp_valid && lat < 10) begin
         step();
         lat++;
      end
      checkOutput("clr_lat", 32'(lat), 32'd3);
      checkOutput("clr_rdata", 32'(rsp_rdata), 32'hA5);
      checkOutput("clr_id", 32'(rsp_id), 32'd1);
      req_valid = 2'b01;
      step();
      checkOutput("clr_idle_ready", 32'(req_ready), 32'd0);
      checkOutput("clr_idle_cs", 32'(sram_cs), 32'd0);
      step();
      checkOutput("clr_srst", 32'(sram_rst), 32'd1);
      checkOutput("clr_clear_ready", 32'(req_ready), 32'd0);
      applyStimulus(0, 1'b0, 3'd3, 8'h00, 3, 8'h00, "clr_rd3");

      $display("[TB] clear beats same-cycle request");
      req_we[0]   = 1'b0;
      req_addr    = {3'd0, 3'd5};
      req_valid   = 2'b01;
      clear_req   = 1'b1;
      #1;
      checkOutput("same_ready", 32'(req_ready), 32'd0);
      step();
      clear_req = 1'b0;
      checkOutput("same_srst", 32'(sram_rst), 32'd1);
      checkOutput("same_clear_ready", 32'(req_ready), 32'd0);
      applyStimulus(0, 1'b0, 3'd5, 8'h00, 3, 8'h00, "same_rd5");

      $display("[TB] reset mid-read");
      applyStimulus(0, 1'b1, 3'd3, 8'h3C, 2, 8'h00, "mid_wr3");
      req_we    = 2'b00;
      req_addr  = {3'd1, 3'd3};
      req_valid = 2'b01;
      #1;
      step();
      req_valid = 2'b11;
      step();
      checkOutput("mid_rwait_cs", 32'(sram_cs), 32'd0);
      checkOutput("mid_rwait_addr", 32'(sram_addr), 32'd3);
      rst = 1'b0;
      #1;
      checkOutput("mid_rst_valid", 32'(rsp_valid), 32'd0);
      checkOutput("mid_rst_rdata", 32'(rsp_rdata), 32'd0);
      checkOutput("mid_rst_addr", 32'(sram_addr), 32'd0);
      checkOutput("mid_rst_init_done", 32'(init_done), 32'd0);
      checkOutput("mid_rst_ready", 32'(req_ready), 32'd0);
      checkOutput("mid_rst_cs", 32'(sram_cs), 32'd0);
      repeat (2) begin
         step();
         checkOutput("mid_hold_valid", 32'(rsp_valid), 32'd0);
      end
      rst = 1'b1;
      #1;
      checkOutput("mid_init_cs", 32'(sram_cs), 32'd0);
      step();
      checkOutput("mid_clear_srst", 32'(sram_rst), 32'd1);
      step();
      checkOutput("mid_init_done", 32'(init_done), 32'd1);
      checkOutput("mid_ptr_reset", 32'(req_ready), 32'd1);
      step();
      req_valid = 2'b00;
      lat = 1;
      while (!rsp_valid && lat < 10) begin
         step();
         lat++;
      end
      checkOutput("mid_rd_lat", 32'(lat), 32'd3);
      checkOutput("mid_rd_rdata", 32'(rsp_rdata), 32'd0);
      checkOutput("mid_rd_id", 32'(rsp_id), 32'd0);
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
Round-robin controller sharing the 8x8 single-port SRAM between N_REQ requesters through a valid/ready request channel and a single response channel.
- Sequences the SRAM's synchronous clear after reset and on demand.
- Drives SRAM cs/re/we so a read and a write are never both asserted.
- Returns read data tagged with the requester id.
- Sits between the bus-side clients and the SRAM instance.

Parameters:
N_REQ, 2, number of requesters (2..8)
DATA_W, 8, SRAM data width
ADDR_W, 3, SRAM address width (depth 2**ADDR_W)
ID_W, $clog2(N_REQ) (min 1), response id width (localparam)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
req_valid  in  N_REQ  per-requester request valid
req_ready  out  N_REQ  per-requester grant/accept, one-hot or zero
req_we  in  N_REQ  1=write, 0=read
req_addr  in  N_REQ*ADDR_W  packed, requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  N_REQ*DATA_W  packed write data
rsp_valid  out  1  response valid
rsp_ready  in  1  response accept
rsp_id  out  ID_W  index of the requester served
rsp_we  out  1  1=write ack, 0=read data
rsp_rdata  out  DATA_W  read data; 0 for write ack
clear_req  in  1  single-cycle pulse requesting a full memory clear
init_done  out  1  high once the first clear has completed
sram_rst, sram_cs, sram_re, sram_we  out  1  SRAM controls
sram_addr  out  ADDR_W  SRAM address
sram_wdata  out  DATA_W  SRAM write data
sram_rdata  in  DATA_W  SRAM data_out

Behaviour:
- Moore FSM. States:
  - INIT: reset state; all sram_* = 0.
  - CLEAR: sram_cs=1, sram_rst=1 for exactly 1 cycle.
  - IDLE
  - WR: sram_cs=1, sram_we=1.
  - RD: sram_cs=1, sram_re=1.
  - RWAIT
  - RESP: rsp_valid=1.
- Transitions:
  - INIT->CLEAR; CLEAR->IDLE, and init_done set (stays 1 until rst).
  - IDLE: if clear pending -> CLEAR; else if any req_valid -> handshake with winner, WR if req_we else RD.
  - WR->RESP; RD->RWAIT->RESP.
  - RESP->IDLE when rsp_ready=1; otherwise hold.
- Handshake:
  - req_ready[i] is combinational, high only in IDLE with no clear pending, and only for the arbitration winner among asserted req_valid.
  - On handshake, addr/wdata/we/id are registered. sram_addr and sram_wdata present these registers and hold them afterwards.
- Arbitration: round-robin with pointer last.
  - Search starts at last+1 mod N_REQ.
  - last updates to the winner on handshake.
  - Reset value of last is N_REQ-1, so requester 0 wins first.
- SRAM timing: SRAM samples cs/re/we at the end of RD/WR. sram_rdata is valid during RWAIT and is captured into rsp_rdata at the end of RWAIT.
- Latency, counted from the handshake cycle:
  - Write ack: rsp_valid 2 cycles later.
  - Read data: rsp_valid 3 cycles later.
  - With rsp_ready tied 1: one write per 3 cycles, one read per 4 cycles.
- RESP stall: rsp_valid, rsp_id, rsp_we and rsp_rdata stay stable while rsp_ready=0. No new grant and no SRAM access occurs during the stall.
- clear_req:
  - Sets a sticky pending flag in any state; the in-flight transaction completes first.
  - In IDLE, a pending clear beats any same-cycle request.
  - The flag clears on entering CLEAR.
  - A pulse arriving while already pending is absorbed.
- Reset, at any time (including mid-transaction): outputs asynchronously return to their reset values.
  - state=INIT; req_ready=0, rsp_valid=0, rsp_id=0, rsp_we=0, rsp_rdata=0.
  - All sram_* = 0, init_done=0, pending=0, last=N_REQ-1.
  - Any in-flight transaction is dropped without a response.
  - Memory is re-cleared via INIT->CLEAR after release.
- Invariants: sram_re & sram_we never both 1; sram_rst only with sram_cs; at most one req_ready bit set.

Optional Feature:
SRAM_ARB_FIXED_PRIO_EN
- Defined: fixed priority, lowest index wins, and the pointer is unused.
- Undefined: round-robin as above.
- All latencies and other behaviour are identical in both modes.

Decomposition:
- Package sram_arb_pkg holds:
  - the state_t enum (INIT, CLEAR, IDLE, WR, RD, RWAIT, RESP);
  - default DATA_W/ADDR_W constants;
  - an id-width function.
- Sub-module sram_rr_arb: winner selection from req_valid plus the pointer register, with an update on grant. The macro selects the fixed-priority path inside it.

Test Plan:
1. Reset-to-ready: rst=0 for 3 cycles, then release -> INIT 1 cycle, CLEAR with sram_cs=sram_rst=1 1 cycle, init_done=1 next; a subsequent read of addr 5 returns rsp_rdata=0x00.
2. Write/read: req0 writes 0xA5 to addr 3 -> rsp_we=1, rsp_id=0, 2 cycles after handshake; req1 reads addr 3 -> rsp_rdata=0xA5, rsp_id=1, 3 cycles after handshake.
3. Contention: both req_valid held, rsp_ready=1 -> grants alternate 0,1,0,1. With SRAM_ARB_FIXED_PRIO_EN -> grants 0,0,0.
4. Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_rdata stable, req_ready=0, sram_cs=0; the response completes on the first rsp_ready=1.
5. Clear ordering:
   - clear_req during a read of addr 3 holding 0xA5 -> read still returns 0xA5, then CLEAR, and the next read of addr 3 returns 0x00.
   - clear_req in the same IDLE cycle as req0 valid -> req_ready=0 until CLEAR is done.
6. Reset mid-read: rst asserted during RWAIT -> all outputs 0 immediately, no response issued; after release, INIT->CLEAR repeats.
